// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32I control unit with a ready/valid memory port, trap/halt states and a memory-wait watchdog.
// Defining INSTRET_EN builds the retired-instruction counter; otherwise o_instret is tied to 0.
module mc_ctrl_fsm #(
  parameter int ALU_W    = 4,
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic             i_zero,
  input  logic             i_lt,
  input  logic             i_ltu,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_adr_src,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic [2:0]       o_imm_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_result_src,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic             o_halted,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_ADR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
    S_WB_ALU, S_EX_BR, S_EX_JAL, S_EX_JALR, S_JALR_PC, S_EX_LUI, S_HALT, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_HALT = 7'b0000000;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_B  = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_J  = 3'd4;
  localparam logic [2:0] IMM_SH = 3'd5;

  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_RS1   = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;
  localparam logic [1:0] B_RS2   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;
  localparam logic [1:0] RES_OUT = 2'd0;
  localparam logic [1:0] RES_MDR = 2'd1;
  localparam logic [1:0] RES_ALU = 2'd2;

  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(9);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = (WAIT_MAX > 0) ? WW'(WAIT_MAX - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [WW-1:0]   r_wait_cnt;
  logic            w_wait_hit;
  logic            w_alt;

  function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                               input logic is_r);
    case (f3)
      3'd0:    return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic z, input logic lt,
                                   input logic ltu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  assign w_alt      = (i_funct7 == 7'b0100000);
  // The access is abandoned on the cycle that would be the WAIT_MAX-th consecutive wait.
  assign w_wait_hit = (WAIT_MAX > 0) && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_imm_src    = IMM_I;
    o_alu_src_a  = 2'd0;
    o_alu_src_b  = B_RS2;
    o_result_src = RES_OUT;
    o_alu_ctrl   = ALU_ADD;
    o_halted     = 1'b0;
    o_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = B_FOUR;
        o_result_src = RES_ALU;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_wait_hit) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        o_alu_src_a = A_OLDPC;
        o_alu_src_b = B_IMM;
        o_imm_src   = (i_opcode == OP_JAL) ? IMM_J : IMM_B;
        case (i_opcode)
          OP_R:    w_next = S_EX_R;
          OP_I:    w_next = S_EX_I;
          OP_LW:   w_next = S_EX_ADR;
          OP_SW:   w_next = S_EX_ADR;
          OP_BR:   w_next = S_EX_BR;
          OP_JAL:  w_next = S_EX_JAL;
          OP_JALR: w_next = S_EX_JALR;
          OP_LUI:  w_next = S_EX_LUI;
          OP_HALT: w_next = S_HALT;
          default: w_next = S_TRAP;
        endcase
      end
      S_EX_R: begin
        o_alu_src_a = A_RS1;
        o_alu_src_b = B_RS2;
        o_alu_ctrl  = alu_op(i_funct3, w_alt, 1'b1);
        w_next      = S_WB_ALU;
      end
      S_EX_I: begin
        o_alu_src_a = A_RS1;
        o_alu_src_b = B_IMM;
        o_imm_src   = (i_funct3 == 3'd1 || i_funct3 == 3'd5) ? IMM_SH : IMM_I;
        o_alu_ctrl  = alu_op(i_funct3, w_alt, 1'b0);
        w_next      = S_WB_ALU;
      end
      S_EX_ADR: begin
        o_alu_src_a = A_RS1;
        o_alu_src_b = B_IMM;
        o_imm_src   = (i_opcode == OP_SW) ? IMM_S : IMM_I;
        w_next      = (i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready)     w_next = S_WB_MEM;
        else if (w_wait_hit) w_next = S_TRAP;
      end
      S_MEM_WR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready)     w_next = S_FETCH;
        else if (w_wait_hit) w_next = S_TRAP;
      end
      S_WB_MEM: begin
        o_result_src = RES_MDR;
        o_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_WB_ALU: begin
        o_result_src = RES_OUT;
        o_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_EX_BR: begin
        o_alu_src_a = A_RS1;
        o_alu_src_b = B_RS2;
        o_alu_ctrl  = ALU_SUB;
        if (i_funct3 == 3'd2 || i_funct3 == 3'd3) begin
          w_next = S_TRAP;
        end else begin
          o_pc_write = br_cond(i_funct3, i_zero, i_lt, i_ltu);
          w_next     = S_FETCH;
        end
      end
      S_EX_JAL: begin
        o_alu_src_a = A_OLDPC;
        o_alu_src_b = B_FOUR;
        o_pc_write  = 1'b1;
        w_next      = S_WB_ALU;
      end
      S_EX_JALR: begin
        o_alu_src_a = A_RS1;
        o_alu_src_b = B_IMM;
        w_next      = S_JALR_PC;
      end
      S_JALR_PC: begin
        o_alu_src_a = A_OLDPC;
        o_alu_src_b = B_FOUR;
        o_pc_write  = 1'b1;
        w_next      = S_WB_ALU;
      end
      S_EX_LUI: begin
        o_alu_src_a = A_ZERO;
        o_alu_src_b = B_IMM;
        o_imm_src   = IMM_U;
        w_next      = S_WB_ALU;
      end
      S_HALT:  o_halted = 1'b1;
      S_TRAP:  o_trap   = 1'b1;
      default: w_next   = S_TRAP;
    endcase
    // Reset must kill an in-flight access immediately, not at the next edge.
    if (i_rst) begin
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_ir_write  = 1'b0;
      o_pc_write  = 1'b0;
      o_reg_write = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_wait_cnt <= '0;
    else if ((WAIT_MAX > 0) && (w_next == r_state) && o_mem_req && !i_mem_ready)
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end

`ifdef INSTRET_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_instret;

  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 1'b1;
  end

  assign o_instret = r_instret;
`else
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level model expands each instruction into its expected output phases.
module tb_mc_ctrl_fsm;
  localparam int ALU_W    = 4;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;

  localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_EXR = 3, P_EXI = 4, P_EXADR = 5,
                 P_MRD = 6, P_MWR = 7, P_WBM = 8, P_WBA = 9, P_EXBR = 10, P_EXJAL = 11,
                 P_EXJALR = 12, P_JALRPC = 13, P_EXLUI = 14, P_HALT = 15, P_TRAP = 16;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

  typedef struct packed {
    logic       req, we, adr, irw, pcw, rw;
    logic [2:0] imm;
    logic [1:0] a, b, rs;
    logic [3:0] alu;
    logic       halt, trap;
  } vec_t;

  logic             i_clk = 1'b0, i_rst = 1'b1;
  logic [6:0]       i_opcode = '0, i_funct7 = '0;
  logic [2:0]       i_funct3 = '0;
  logic             i_zero = 1'b0, i_lt = 1'b0, i_ltu = 1'b0, i_mem_ready = 1'b0;
  logic             o_mem_req, o_mem_we, o_adr_src, o_ir_write, o_pc_write, o_reg_write;
  logic [2:0]       o_imm_src;
  logic [1:0]       o_alu_src_a, o_alu_src_b, o_result_src;
  logic [ALU_W-1:0] o_alu_ctrl;
  logic             o_halted, o_trap;
  logic [CNT_W-1:0] o_instret;

  mc_ctrl_fsm #(.ALU_W(ALU_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7(i_funct7), .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_adr_src(o_adr_src), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
    .o_reg_write(o_reg_write), .o_imm_src(o_imm_src), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_result_src(o_result_src), .o_alu_ctrl(o_alu_ctrl),
    .o_halted(o_halted), .o_trap(o_trap), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0, n_fail = 0;
  int          cur_ph = P_RST;
  vec_t        exp_v = '0;
  bit          chk_en = 1'b0;
  int          model_ret = 0;
  int          ncyc = 0, n_regw = 0, n_pcw = 0, n_memadr = 0, n_strobe = 0;
  logic [3:0]  obs_alu = '0;
  logic [31:0] rs1v = '0, rs2v = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] alu_model(input bit is_r);
    int tab [8];
    int code;
    tab  = '{0, 7, 5, 6, 4, 8, 3, 2};
    code = tab[i_funct3];
    if (i_funct7 == 7'b0100000) begin
      if (is_r && i_funct3 == 3'd0) code = 1;
      if (i_funct3 == 3'd5) code = 9;
    end
    return 4'(code);
  endfunction

  function automatic logic taken_model();
    case (i_funct3)
      3'd0:    return rs1v == rs2v;
      3'd1:    return rs1v != rs2v;
      3'd4:    return $signed(rs1v) < $signed(rs2v);
      3'd5:    return $signed(rs1v) >= $signed(rs2v);
      3'd6:    return rs1v < rs2v;
      3'd7:    return rs1v >= rs2v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t exp_of(input int ph, input logic rdy);
    vec_t e;
    e = '0;
    case (ph)
      P_FETCH:  begin e.req = 1; e.b = 2; e.rs = 2; e.irw = rdy; e.pcw = rdy; end
      P_DEC:    begin e.a = 1; e.b = 1; e.imm = (i_opcode == OP_JAL) ? 3'd4 : 3'd2; end
      P_EXR:    begin e.a = 2; e.b = 0; e.alu = alu_model(1'b1); end
      P_EXI:    begin
        e.a = 2; e.b = 1; e.alu = alu_model(1'b0);
        e.imm = (i_funct3 == 3'd1 || i_funct3 == 3'd5) ? 3'd5 : 3'd0;
      end
      P_EXADR:  begin e.a = 2; e.b = 1; e.imm = (i_opcode == OP_SW) ? 3'd1 : 3'd0; end
      P_MRD:    begin e.req = 1; e.adr = 1; end
      P_MWR:    begin e.req = 1; e.we = 1; e.adr = 1; end
      P_WBM:    begin e.rs = 1; e.rw = 1; end
      P_WBA:    begin e.rw = 1; end
      P_EXBR:   begin e.a = 2; e.b = 0; e.alu = 1; e.pcw = taken_model(); end
      P_EXJAL:  begin e.a = 1; e.b = 2; e.pcw = 1; end
      P_EXJALR: begin e.a = 2; e.b = 1; end
      P_JALRPC: begin e.a = 1; e.b = 2; e.pcw = 1; end
      P_EXLUI:  begin e.a = 3; e.b = 1; e.imm = 3; end
      P_HALT:   e.halt = 1;
      P_TRAP:   e.trap = 1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  always @(negedge i_clk) begin
    vec_t act;
    logic [CNT_W-1:0] ei;
    if (chk_en) begin
      act = '{o_mem_req, o_mem_we, o_adr_src, o_ir_write, o_pc_write, o_reg_write,
              o_imm_src, o_alu_src_a, o_alu_src_b, o_result_src, o_alu_ctrl, o_halted, o_trap};
      if (cur_ph == P_RST) begin
        act.adr = 0; act.imm = 0; act.a = 0; act.b = 0; act.rs = 0; act.alu = 0;
      end
`ifdef INSTRET_EN
      ei = CNT_W'(model_ret);
`else
      ei = '0;
`endif
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL outputs phase=%0d: got %h expected %h at %0t", cur_ph, act, exp_v, $time);
      end
      n_tests++;
      if (o_instret !== ei) begin
        n_fail++;
        $display("FAIL instret phase=%0d: got %0d expected %0d at %0t", cur_ph, o_instret, ei, $time);
      end
      if (o_reg_write) n_regw++;
      if (o_pc_write) n_pcw++;
      if (o_mem_req && o_adr_src) n_memadr++;
      if (o_mem_req || o_mem_we || o_ir_write || o_pc_write || o_reg_write) n_strobe++;
      if (cur_ph == P_EXR) obs_alu = o_alu_ctrl;
    end
  end

  task automatic do_cycle(input int ph, input logic rdy);
    cur_ph      = ph;
    i_mem_ready = rdy;
    exp_v       = exp_of(ph, rdy);
    chk_en      = 1'b1;
    @(posedge i_clk);
    #1;
    ncyc++;
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    model_ret = 0;
    do_cycle(P_RST, 1'($urandom_range(0, 1)));
    do_cycle(P_RST, 1'($urandom_range(0, 1)));
    i_rst = 1'b0;
  endtask

  task automatic clr_obs();
    ncyc = 0; n_regw = 0; n_pcw = 0; n_memadr = 0; n_strobe = 0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
    i_opcode = op; i_funct3 = f3; i_funct7 = f7;
    rs1v = a; rs2v = b;
    i_zero = (a == b);
    i_lt   = ($signed(a) < $signed(b));
    i_ltu  = (a < b);
  endtask

  task automatic mem_phase(input int ph, input int w, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < w; i++) begin
      do_cycle(ph, 1'b0);
      if (i + 1 == WAIT_MAX) begin
        trapped = 1'b1;
        return;
      end
    end
    do_cycle(ph, 1'b1);
  endtask

  // st: 0 retired, 1 halted, 2 trapped
  task automatic run_instr(input int wf, input int wm, output int st);
    bit t;
    st = 2;
    mem_phase(P_FETCH, wf, t);
    if (t) return;
    do_cycle(P_DEC, 1'($urandom_range(0, 1)));
    case (i_opcode)
      OP_R:    begin do_cycle(P_EXR, 1'($urandom_range(0, 1))); do_cycle(P_WBA, 1'b1); end
      OP_I:    begin do_cycle(P_EXI, 1'($urandom_range(0, 1))); do_cycle(P_WBA, 1'b0); end
      OP_LW:   begin
        do_cycle(P_EXADR, 1'b1);
        mem_phase(P_MRD, wm, t);
        if (t) return;
        do_cycle(P_WBM, 1'($urandom_range(0, 1)));
      end
      OP_SW:   begin
        do_cycle(P_EXADR, 1'b0);
        mem_phase(P_MWR, wm, t);
        if (t) return;
      end
      OP_BR:   begin
        do_cycle(P_EXBR, 1'($urandom_range(0, 1)));
        if (i_funct3 == 3'd2 || i_funct3 == 3'd3) return;
      end
      OP_JAL:  begin do_cycle(P_EXJAL, 1'b0); do_cycle(P_WBA, 1'b1); end
      OP_JALR: begin
        do_cycle(P_EXJALR, 1'b1); do_cycle(P_JALRPC, 1'b0); do_cycle(P_WBA, 1'b1);
      end
      OP_LUI:  begin do_cycle(P_EXLUI, 1'b0); do_cycle(P_WBA, 1'b0); end
      7'b0000000: begin st = 1; return; end
      default: return;
    endcase
    st = 0;
    model_ret = (model_ret + 1) % (1 << CNT_W);
  endtask

  task automatic finish_stuck(input int st, input int n);
    for (int i = 0; i < n; i++) do_cycle((st == 1) ? P_HALT : P_TRAP, 1'($urandom_range(0, 1)));
    do_reset();
  endtask

  int          st;
  int          ret_exp;
  logic [6:0]  rop;
  logic [6:0]  rf7;
  logic [31:0] ra, rb;
  int          k, wf, wm;

  initial begin
    @(posedge i_clk);
    #1;
    do_reset();

    set_instr(OP_R, 3'd0, 7'd0, 32'd5, 32'd7);
    clr_obs();
    run_instr(0, 0, st);
    chk("add_status", st, 0);
    chk("add_cycles", ncyc, 4);
    chk("add_regwrite_pulses", n_regw, 1);
    chk("add_alu_ctrl", obs_alu, 0);
`ifdef INSTRET_EN
    ret_exp = 1;
`else
    ret_exp = 0;
`endif
    chk("add_instret", o_instret, ret_exp);

    set_instr(OP_LW, 3'd2, 7'd0, 32'd100, 32'd0);
    clr_obs();
    run_instr(0, 3, st);
    chk("lw_cycles", ncyc, 8);
    chk("lw_mem_adr_cycles", n_memadr, 4);

    set_instr(OP_BR, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1);
    clr_obs(); run_instr(0, 0, st);
    chk("blt_taken_pcw", n_pcw, 2);
    set_instr(OP_BR, 3'd4, 7'd0, 32'd5, 32'd3);
    clr_obs(); run_instr(0, 0, st);
    chk("blt_not_taken_pcw", n_pcw, 1);
    set_instr(OP_BR, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'd1);
    clr_obs(); run_instr(0, 0, st);
    chk("bltu_ignores_lt", n_pcw, 1);
    set_instr(OP_BR, 3'd6, 7'd0, 32'd1, 32'hFFFF_FFFF);
    clr_obs(); run_instr(0, 0, st);
    chk("bltu_taken_pcw", n_pcw, 2);

    set_instr(OP_JALR, 3'd0, 7'd0, 32'd64, 32'd0);
    clr_obs(); run_instr(0, 0, st);
    chk("jalr_cycles", ncyc, 5);
    chk("jalr_regwrite_pulses", n_regw, 1);

    set_instr(OP_R, 3'd0, 7'd0, 32'd1, 32'd2);
    clr_obs(); run_instr(4, 0, st);
    chk("wd_status", st, 2);
    chk("wd_cycles", ncyc, 4);
    do_cycle(P_TRAP, 1'b1); do_cycle(P_TRAP, 1'b0);
    chk("wd_trap", o_trap, 1);
    chk("wd_req_dropped", o_mem_req, 0);
    do_reset();
    chk("wd_reset_instret", o_instret, 0);

    set_instr(7'b1111111, 3'd0, 7'd0, 32'd0, 32'd0);
    clr_obs(); run_instr(1, 0, st);
    chk("illegal_status", st, 2);
    finish_stuck(2, 3);

    set_instr(OP_BR, 3'd2, 7'd0, 32'd0, 32'd0);
    run_instr(0, 0, st);
    chk("bad_branch_status", st, 2);
    finish_stuck(2, 2);

    set_instr(7'b0000000, 3'd0, 7'd0, 32'd0, 32'd0);
    run_instr(0, 0, st);
    chk("halt_status", st, 1);
    clr_obs();
    for (int i = 0; i < 20; i++) do_cycle(P_HALT, 1'($urandom_range(0, 1)));
    chk("halt_no_strobes", n_strobe, 0);
    do_reset();

    set_instr(OP_LW, 3'd2, 7'd0, 32'd8, 32'd0);
    do_cycle(P_FETCH, 1'b1); do_cycle(P_DEC, 1'b0); do_cycle(P_EXADR, 1'b0);
    do_cycle(P_MRD, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("rst_drops_req", o_mem_req, 0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      set_instr(OP_I, 3'($urandom_range(0, 7)), 7'd0, $urandom, $urandom);
      run_instr(0, 0, st);
    end
`ifdef INSTRET_EN
    ret_exp = 4;
`else
    ret_exp = 0;
`endif
    chk("instret_wrap", o_instret, ret_exp);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      case (k)
        0, 1, 2, 3:  rop = OP_R;
        4, 5, 6, 7:  rop = OP_I;
        8, 9:        rop = OP_LW;
        10, 11:      rop = OP_SW;
        12, 13, 14:  rop = OP_BR;
        15:          rop = OP_JAL;
        16:          rop = OP_JALR;
        17:          rop = OP_LUI;
        18:          rop = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0010111;
        default:     rop = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b1110011;
      endcase
      case ($urandom_range(0, 2))
        0:       rf7 = 7'b0000000;
        1:       rf7 = 7'b0100000;
        default: rf7 = 7'($urandom);
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      wf = ($urandom_range(0, 15) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
      wm = ($urandom_range(0, 15) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
      set_instr(rop, 3'($urandom_range(0, 7)), rf7, ra, rb);
      run_instr(wf, wm, st);
      if (st != 0) finish_stuck(st, $urandom_range(1, 4));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle RV32I control unit that replaces the fixed-latency controller. Adds a memory ready/valid handshake for variable-latency memory, full branch coverage (BEQ/BNE/BLT/BGE/BLTU/BGEU) and shift ALU codes. Also adds an illegal-opcode trap, a HALT state and a memory-wait watchdog. Sits between the instruction register and the shared datapath: PC, IR, register file, ALU, ALUOut and unified memory.

Parameters:
ALU_W, 4, width of alu_ctrl; must be >=4.
CNT_W, 32, width of the retired-instruction counter.
WAIT_MAX, 15, max consecutive mem_ready-low cycles before a trap; 0 disables the watchdog.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zero  in  1  ALU result == 0
lt  in  1  signed rs1<rs2 from datapath comparator
ltu  in  1  unsigned rs1<rs2
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request; held until mem_ready
mem_we  out  1  write strobe, valid with mem_req
adr_src  out  1  0=PC, 1=ALUOut
ir_write  out  1  latch IR and OldPC
pc_write  out  1  PC <= result
reg_write  out  1  rd <= result
imm_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 I-shamt
alu_src_a  out  2  0 PC, 1 OldPC, 2 rs1, 3 zero
alu_src_b  out  2  0 rs2, 1 imm, 2 const 4
result_src  out  2  0 ALUOut, 1 MDR, 2 ALU result
alu_ctrl  out  ALU_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
halted  out  1  FSM in HALT
trap  out  1  sticky; FSM in TRAP
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - State is FETCH; all strobes are 0 and instret is 0.
  - The FETCH outputs take effect the cycle after rst falls, so mem_req=1 in that cycle.
- All outputs are a combinational function of state and the IR fields; the state register is the only sequential element besides the counters.
- States and outputs:
  - FETCH: mem_req=1, adr_src=0, a=PC, b=4, add, result_src=2.
    - Hold while mem_ready=0, with ir_write=0 and pc_write=0.
    - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - DECODE: a=OldPC, b=imm, add; imm_src=J if opcode is JAL, else B. This precomputes the branch/jump target into ALUOut.
    - R(0110011) -> EX_R; I-ALU(0010011) -> EX_I; LW/SW -> EX_ADR; BRANCH -> EX_BR; JAL -> EX_JAL; JALR -> EX_JALR; LUI -> EX_LUI.
    - opcode 0000000 -> HALT; any other opcode -> TRAP.
  - EX_R: a=rs1, b=rs2. funct3 0 gives add, or sub when funct7=0100000. Other funct3 values map to the codes above. Next is WB_ALU.
  - EX_I: a=rs1, b=imm. imm_src=5 for funct3 1/5, else 0. funct3 5 with funct7=0100000 gives sra. Next is WB_ALU.
  - EX_ADR: a=rs1, b=imm, add; imm_src=S for SW, I for LW. Next is MEM_WR for SW, MEM_RD for LW.
  - MEM_RD: mem_req=1, adr_src=1. Wait for mem_ready, then go to WB_MEM.
  - MEM_WR: mem_req=1, mem_we=1, adr_src=1. Wait for mem_ready, then go to FETCH (retire).
  - WB_MEM: result_src=1, reg_write=1. Next is FETCH (retire).
  - WB_ALU: result_src=0, reg_write=1. Next is FETCH (retire).
  - EX_BR: a=rs1, b=rs2, sub, result_src=0. pc_write = condition, evaluated from zero/lt/ltu per funct3 0/1/4/5/6/7.
    - funct3 2 or 3 -> TRAP with pc_write=0.
    - Otherwise go to FETCH (retire).
  - EX_JAL: a=OldPC, b=4, add, result_src=0, pc_write=1. Next is WB_ALU.
  - EX_JALR: a=rs1, b=imm(I), add. Next is JALR_PC.
  - JALR_PC: a=OldPC, b=4, result_src=0, pc_write=1. PC receives rs1+imm with bit0 cleared; the datapath masks bit0, and that masking is enabled during JALR_PC only. Next is WB_ALU.
  - EX_LUI: a=zero, b=imm(U), add. Next is WB_ALU.
  - HALT: all strobes 0; halted=1. Leaves only on rst.
  - TRAP: all strobes 0; trap=1. Leaves only on rst.
- Watchdog (WAIT_MAX>0):
  - A wait counter increments each cycle that mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - When the count reaches WAIT_MAX, the next state is TRAP and the request is dropped.
  - mem_ready arriving in that same cycle wins: the access completes normally.
- Retire: instret increments by 1 on entry to FETCH from any state except reset, HALT and TRAP. It wraps modulo 2^CNT_W.
- rst mid-operation aborts any access; mem_req drops asynchronously.

Optional Feature:
INSTRET_EN
- Defined: instret counter implemented as above.
- Undefined: no counter flops; instret is tied to 0; all other behaviour is identical.

Test Plan:
- ADD x3,x1,x2 (funct7=0) with mem_ready always 1 -> 4 cycles FETCH/DECODE/EX_R/WB_ALU; alu_ctrl=0 in EX_R; reg_write=1 for exactly 1 cycle; instret 0->1.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_req=1 and adr_src=1 held for 4 cycles; WB_MEM follows with result_src=1; 8 cycles total.
- BLT with lt=1, then again with lt=0 -> pc_write=1 in EX_BR in the first case, 0 in the second; BLTU uses ltu only.
- JALR -> pc_write in JALR_PC, reg_write in WB_ALU; 5 cycles total; DECODE imm_src=B, EX_JALR imm_src=I.
- WAIT_MAX=4 with mem_ready stuck at 0 in FETCH -> trap=1 after 4 wait cycles; mem_req=0 thereafter; rst pulse returns to FETCH with instret=0.
- opcode 1111111 -> TRAP after DECODE; opcode 0000000 -> halted=1 with no strobes asserted for 20 cycles.
